// File: rtl/conv_row_sequencer.sv
// rtl/conv_row_sequencer.sv - frame controller feeding 3-row windows to the smoother datapath
//
// Purpose:
//   Reads image rows from the input row RAM and maintains a top/mid/bot
//   sliding window with edge-row replication at the first and last row.
//   Each window is handed to the convolution datapath over a valid/ready
//   handshake. Each result row is written to the output RAM in address order.
//
// Ports:
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_start               one-cycle frame start (honoured in IDLE or DONE)
//   o_in_rd_en/o_in_addr  input RAM read strobe and row address
//   i_in_data             input RAM data, valid RD_LAT cycles after the strobe
//   o_row_top/mid/bot     window rows r-1 / r / r+1 (edge rows replicated)
//   o_conv_valid          window valid, held until i_conv_ready
//   i_conv_ready          datapath accepts the window
//   i_conv_res_valid      datapath result strobe, with i_conv_res
//   o_out_we/addr/data    output RAM write port, one strobe per row
//   o_busy                frame in progress
//   o_conv_done           sticky frame-complete flag
module conv_row_sequencer #(
  parameter int ROWS   = 128,
  parameter int ROW_W  = 1024,
  parameter int ADDR_W = 7,
  parameter int RD_LAT = 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  output logic              o_in_rd_en,
  output logic [ADDR_W-1:0] o_in_addr,
  input  logic [ROW_W-1:0]  i_in_data,
  output logic [ROW_W-1:0]  o_row_top,
  output logic [ROW_W-1:0]  o_row_mid,
  output logic [ROW_W-1:0]  o_row_bot,
  output logic              o_conv_valid,
  input  logic              i_conv_ready,
  input  logic              i_conv_res_valid,
  input  logic [ROW_W-1:0]  i_conv_res,
  output logic              o_out_we,
  output logic [ADDR_W-1:0] o_out_addr,
  output logic [ROW_W-1:0]  o_out_data,
  output logic              o_busy,
  output logic              o_conv_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRIME0,
    S_PRIME1,
    S_ISSUE,
    S_WAIT_RES,
    S_WRITE,
    S_FETCH,
    S_DONE
  } state_t;

  localparam int                WAIT_W     = $clog2(RD_LAT + 1);
  localparam logic [ADDR_W-1:0] LAST_ROW   = ADDR_W'(ROWS - 1);
  // One extra bit so r+2 cannot wrap when compared against the last row.
  localparam logic [ADDR_W:0]   LAST_ROW_X = (ADDR_W + 1)'(ROWS - 1);

  state_t              r_state;
  state_t              w_state_next;
  logic [ADDR_W-1:0]   r_row;
  logic [WAIT_W-1:0]   r_wait;
  logic [ADDR_W-1:0]   r_in_addr;
  logic [ROW_W-1:0]    r_top;
  logic [ROW_W-1:0]    r_mid;
  logic [ROW_W-1:0]    r_bot;
  logic [ADDR_W-1:0]   r_out_addr;
  logic [ROW_W-1:0]    r_out_data;

  logic                w_is_read;
  logic                w_capture;
  logic                w_start_ok;
  logic                w_last_row;
  logic                w_fetch_more;
  logic [ADDR_W-1:0]   w_row_plus2;

  // r_wait counts cycles since the read strobe; the strobe is the cycle
  // where it is still 0, the capture is the cycle where it reaches RD_LAT.
  assign w_is_read    = (r_state == S_PRIME0) || (r_state == S_PRIME1) ||
                        (r_state == S_FETCH);
  assign w_capture    = w_is_read && (r_wait == WAIT_W'(RD_LAT));
  assign w_start_ok   = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last_row   = (r_row == LAST_ROW);
  assign w_fetch_more = ({1'b0, r_row} + (ADDR_W + 1)'(2)) <= LAST_ROW_X;
  assign w_row_plus2  = r_row + ADDR_W'(2);

  always_comb begin
    w_state_next = r_state;
    o_in_rd_en   = 1'b0;
    o_conv_valid = 1'b0;
    o_out_we     = 1'b0;
    o_busy       = 1'b0;
    o_conv_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start_ok) w_state_next = S_PRIME0;
      end
      S_PRIME0: begin
        o_busy     = 1'b1;
        o_in_rd_en = (r_wait == '0);
        if (w_capture) w_state_next = (ROWS == 1) ? S_ISSUE : S_PRIME1;
      end
      S_PRIME1, S_FETCH: begin
        o_busy     = 1'b1;
        o_in_rd_en = (r_wait == '0);
        if (w_capture) w_state_next = S_ISSUE;
      end
      S_ISSUE: begin
        o_busy       = 1'b1;
        o_conv_valid = 1'b1;
        if (i_conv_ready) w_state_next = S_WAIT_RES;
      end
      S_WAIT_RES: begin
        o_busy = 1'b1;
        if (i_conv_res_valid) w_state_next = S_WRITE;
      end
      S_WRITE: begin
        o_busy   = 1'b1;
        o_out_we = 1'b1;
        if (w_last_row)        w_state_next = S_DONE;
        else if (w_fetch_more) w_state_next = S_FETCH;
        else                   w_state_next = S_ISSUE;
      end
      S_DONE: begin
        o_conv_done = 1'b1;
        if (w_start_ok) w_state_next = S_PRIME0;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_row      <= '0;
      r_wait     <= '0;
      r_in_addr  <= '0;
      r_top      <= '0;
      r_mid      <= '0;
      r_bot      <= '0;
      r_out_addr <= '0;
      r_out_data <= '0;
    end else begin
      r_state <= w_state_next;

      if (w_is_read) r_wait <= w_capture ? '0 : r_wait + WAIT_W'(1);

      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_start_ok) begin
            r_row     <= '0;
            r_wait    <= '0;
            r_in_addr <= '0;
          end
        end
        S_PRIME0: begin
          if (w_capture) begin
            // Top edge: row 0 stands in for the missing row -1.
            r_top <= i_in_data;
            r_mid <= i_in_data;
            if (ROWS == 1) r_bot <= i_in_data;
            else           r_in_addr <= ADDR_W'(1);
          end
        end
        S_PRIME1, S_FETCH: begin
          if (w_capture) r_bot <= i_in_data;
        end
        S_WAIT_RES: begin
          if (i_conv_res_valid) begin
            r_out_data <= i_conv_res;
            r_out_addr <= r_row;
          end
        end
        S_WRITE: begin
          if (!w_last_row) begin
            r_row <= r_row + ADDR_W'(1);
            r_top <= r_mid;
            r_mid <= r_bot;
            // Without a further fetch r_bot keeps the last row (bottom edge).
            if (w_fetch_more) r_in_addr <= w_row_plus2;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_in_addr  = r_in_addr;
  assign o_row_top  = r_top;
  assign o_row_mid  = r_mid;
  assign o_row_bot  = r_bot;
  assign o_out_addr = r_out_addr;
  assign o_out_data = r_out_data;

endmodule

// File: doc/conv_row_sequencer.md
Name: conv_row_sequencer

Overview:
- Frame-level controller for the image smoother.
- Reads input image rows from the input row RAM and keeps a 3-row sliding window (top/mid/bot) with edge-row replication.
- Presents each window to the convolution datapath over a valid/ready handshake, then writes each result row to the output RAM in address order.
- Asserts conv_done after the last row is written.

Parameters:
- ROWS, 128, image height in rows (≥1).
- ROW_W, 1024, bits per row (128 pixels × 8 bit).
- ADDR_W, 7, row address width (2^ADDR_W ≥ ROWS).
- RD_LAT, 1, input RAM read latency in cycles (≥1).

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse, begins a frame (honoured only in IDLE or DONE)
- in_rd_en  out  1  input RAM read strobe, one-cycle pulse
- in_addr  out  ADDR_W  input RAM row address, valid with in_rd_en
- in_data  in  ROW_W  input RAM read data, valid exactly RD_LAT cycles after in_rd_en
- row_top  out  ROW_W  window row r-1 (or row 0 when r=0)
- row_mid  out  ROW_W  window row r
- row_bot  out  ROW_W  window row r+1 (or row ROWS-1 when r=ROWS-1)
- conv_valid  out  1  window valid to datapath
- conv_ready  in  1  datapath accepts the window
- conv_res_valid  in  1  datapath result strobe
- conv_res  in  ROW_W  datapath result row
- out_we  out  1  output RAM write strobe, one cycle per row
- out_addr  out  ADDR_W  output RAM row address
- out_data  out  ROW_W  output RAM write data
- busy  out  1  high from start acceptance until the last write
- conv_done  out  1  sticky frame-complete flag

Behaviour:
- Reset (sync): state=IDLE, row counter r=0, read-wait counter=0; all outputs and window registers 0.
- States: IDLE, PRIME0, PRIME1, ISSUE, WAIT_RES, WRITE, FETCH, DONE.
- Reads (PRIME0/PRIME1/FETCH):
  - On state entry, in_rd_en=1 for exactly one cycle with in_addr set.
  - Then wait; in_data is captured on the cycle that is RD_LAT cycles after the in_rd_en cycle, and the state advances on that same edge.
  - in_addr holds its value until the next read.
- IDLE: busy=0. start=1 → PRIME0, busy=1, r=0.
- PRIME0: read row 0; load row_top and row_mid with it.
  - ROWS=1: also load row_bot, go to ISSUE.
  - Otherwise go to PRIME1.
- PRIME1: read row 1 into row_bot → ISSUE.
- ISSUE:
  - conv_valid=1, window registers stable.
  - On the cycle conv_valid & conv_ready: conv_valid drops next cycle → WAIT_RES.
  - conv_valid must not drop before acceptance.
- WAIT_RES: on conv_res_valid, out_data<=conv_res and out_addr<=r → WRITE. conv_res_valid in any other state is ignored.
- WRITE: out_we=1 for one cycle.
  - If r==ROWS-1 → DONE.
  - Else r<=r+1; row_top<=row_mid; row_mid<=row_bot.
  - If r+2 ≤ ROWS-1 → FETCH (row r+2 into row_bot). Else row_bot is unchanged (bottom-edge replicate) → ISSUE.
- DONE: busy=0, conv_done=1 until reset or an accepted start. start in DONE clears conv_done and behaves as in IDLE.
- start while busy: ignored, no effect on the current frame.
- Ordering guarantees:
  - Input rows are read exactly once each, ascending 0..ROWS-1.
  - Output rows are written exactly once each, ascending 0..ROWS-1.
  - Exactly ROWS conv handshakes per frame.
- Reset mid-frame: immediate return to IDLE, conv_done=0, no further reads or writes. A new start replays from row 0.
- Address arithmetic is ADDR_W bits wide; r never exceeds ROWS-1, so no wrap.

Test Plan:
- ROWS=4, RD_LAT=1, in_data = row index replicated in every byte, conv_ready tied 1, conv_res = row_mid XOR 0xFF.. one cycle after handshake → window (top,mid,bot) per handshake = (0,0,1), (0,1,2), (1,2,3), (2,3,3). in_addr sequence 0,1,2,3; out_addr 0,1,2,3; conv_done=1 after the 4th out_we.
- Same setup, conv_ready low for 5 cycles at row 1 → conv_valid and window held constant for those 5 cycles; exactly one handshake for row 1.
- RD_LAT=3 → in_data captured 3 cycles after each in_rd_en; window contents identical to the first scenario.
- ROWS=1 → one read (addr 0), window (0,0,0), one write to addr 0, conv_done=1.
- reset asserted in WAIT_RES of row 2 → next cycle IDLE, busy=0, conv_done=0, no out_we. A following start rereads from addr 0.
- start pulsed during busy, then again after DONE → first pulse ignored; second clears conv_done and runs a full frame of 4 writes.
